pjdl_rx_axis_packer: RTL and testbench

Packs the byte stream produced by the PJDL receiver into 32-bit AXI-Stream words with per-byte strobes and `last` marking the packet end. A small output FIFO buffers the words. The stream feeds the iDMA backend's AXI-Stream read port, whose `tvalid`/`last` the PJDL iDMA midend also monitors to split and terminate transfers. It also reports per-packet byte count and error status to the register file.

---
 rtl/pjdl_rx_axis_packer_pkg.sv | 37 +++
 rtl/pjdl_rx_axis_packer_if.sv | 10 +
 rtl/fifo_v3.sv | 75 +++++++
 rtl/pjdl_rx_axis_packer.sv | 152 +++++++++++++++
 tb/tb_pjdl_rx_axis_packer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pjdl_rx_axis_packer_pkg.sv
// Shared types for the PJDL receive path: FIFO payload word, AXI-Stream
// request/response structs and the packet length type.
package pjdl_pkg;

    localparam int unsigned PjdlAxisDataWidth = 32;
    localparam int unsigned PjdlAxisStrbWidth = 4;

    typedef logic [15:0] pjdl_plen_t;

    typedef struct packed {
        logic [PjdlAxisDataWidth-1:0] data;
        logic [PjdlAxisStrbWidth-1:0] strb;
        logic                         last;
    } pjdl_axis_word_t;

    typedef struct packed {
        logic [PjdlAxisDataWidth-1:0] data;
        logic [PjdlAxisStrbWidth-1:0] strb;
        logic [PjdlAxisStrbWidth-1:0] keep;
        logic                         last;
    } pjdl_axis_t;

    typedef struct packed {
        logic       tvalid;
        pjdl_axis_t t;
    } pjdl_axis_req_t;

    typedef struct packed {
        logic tready;
    } pjdl_axis_rsp_t;

    // Length counter sticks at all-ones instead of wrapping.
    function automatic pjdl_plen_t pjdl_plen_inc(input pjdl_plen_t v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pjdl_rx_axis_packer_if.sv
// AXI-Stream link between the packer (master) and the iDMA backend (slave).
interface pjdl_rx_axis_packer_if;
    import pjdl_pkg::*;

    pjdl_axis_req_t axis_req;
    pjdl_axis_rsp_t axis_rsp;

    modport master (output axis_req, input axis_rsp);
    modport slave  (input axis_req, output axis_rsp);
endinterface

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with registered full/empty derived from an occupancy count.
// Latency: 1 cycle push-to-head (0 when FALL_THROUGH and empty).
// Backpressure: pushes while full and pops while empty are ignored.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         DATA_TYPE    = logic [31:0]
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     flush_i,
    output logic     full_o,
    output logic     empty_o,
    input  DATA_TYPE data_i,
    input  logic     push_i,
    output DATA_TYPE data_o,
    input  logic     pop_i
);
    localparam int unsigned          AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrW:0]       FullCnt = DEPTH[AddrW:0];
    localparam logic [AddrW-1:0]     PtrOne  = AddrW'(1);
    localparam logic [AddrW:0]       CntOne  = (AddrW+1)'(1);

    DATA_TYPE         mem_q [DEPTH];
    DATA_TYPE         mem_d [DEPTH];
    logic [AddrW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AddrW:0]   cnt_q, cnt_d;

    always_comb begin
        full_o  = (cnt_q == FullCnt);
        empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
        data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_q];
    end

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push_i && !full_o) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + PtrOne;
            cnt_d       = cnt_d + CntOne;
        end
        if (pop_i && !empty_o) begin
            rd_d  = rd_q + PtrOne;
            cnt_d = cnt_d - CntOne;
        end
        // Bypassed word never touches storage.
        if (FALL_THROUGH && (cnt_q == '0) && push_i && pop_i) begin
            rd_d  = rd_q;
            wr_d  = wr_q;
            cnt_d = cnt_q;
        end
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/pjdl_rx_axis_packer.sv
// Packs PJDL receive bytes into 32-bit AXI-Stream words with strobes/last and reports packet status.
// Latency: word visible on tvalid one cycle after its completing byte; status one cycle after push.
// Backpressure: byte ready drops while the output FIFO is full or an abort is waiting to be flushed.
module pjdl_rx_axis_packer
    import pjdl_pkg::*;
#(
    parameter int unsigned FifoDepth  = 4,
    parameter type         axis_req_t = pjdl_axis_req_t,
    parameter type         axis_rsp_t = pjdl_axis_rsp_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_byte_valid_i,
    input  logic       rx_eop_i,
    output logic       rx_byte_ready_o,
    input  logic       rx_abort_i,
    output axis_req_t  axis_req_o,
    input  axis_rsp_t  axis_rsp_i,
    output logic       pkt_done_o,
    output pjdl_plen_t pkt_len_o,
    output logic       pkt_err_o
);
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      strb_q, strb_d;
    pjdl_plen_t      plen_q, plen_d;
    logic            abort_pend_q, abort_pend_d;
    logic            pkt_done_q, pkt_done_d;
    pjdl_plen_t      pkt_len_q, pkt_len_d;
    logic            pkt_err_q, pkt_err_d;

    logic            fifo_full, fifo_empty, fifo_push;
    pjdl_axis_word_t push_word, fifo_head;
    logic            byte_acc;
    logic [31:0]     lane_data;
    logic [3:0]      lane_strb;

    assign rx_byte_ready_o = !fifo_full && !abort_pend_q;
    assign byte_acc        = rx_byte_valid_i && rx_byte_ready_o;

    always_comb begin
        bcnt_d       = bcnt_q;
        data_d       = data_q;
        strb_d       = strb_q;
        plen_d       = plen_q;
        abort_pend_d = abort_pend_q;
        pkt_done_d   = 1'b0;
        pkt_len_d    = pkt_len_q;
        pkt_err_d    = pkt_err_q;
        fifo_push    = 1'b0;
        push_word    = '0;
        lane_data    = data_q;
        lane_data[{bcnt_q, 3'b000} +: 8] = rx_byte_i;
        lane_strb    = strb_q;
        lane_strb[bcnt_q] = 1'b1;

        if (byte_acc) begin
            if ((bcnt_q == 2'd3) || rx_eop_i) begin
                fifo_push      = 1'b1;
                push_word.data = lane_data;
                push_word.strb = lane_strb;
                push_word.last = rx_eop_i;
                bcnt_d         = '0;
                data_d         = '0;
                strb_d         = '0;
            end else begin
                bcnt_d = bcnt_q + 2'd1;
                data_d = lane_data;
                strb_d = lane_strb;
            end
            // An abort arriving with the eop byte is moot: the packet is already complete.
            if (rx_eop_i) begin
                plen_d     = '0;
                pkt_done_d = 1'b1;
                pkt_len_d  = pjdl_plen_inc(plen_q);
                pkt_err_d  = 1'b0;
            end else begin
                plen_d       = pjdl_plen_inc(plen_q);
                abort_pend_d = rx_abort_i;
            end
        end else if (abort_pend_q && !fifo_full) begin
            abort_pend_d = 1'b0;
            if (plen_q != '0) begin
                fifo_push      = 1'b1;
                push_word.data = data_q;
                push_word.strb = strb_q;
                push_word.last = 1'b1;
                bcnt_d         = '0;
                data_d         = '0;
                strb_d         = '0;
                plen_d         = '0;
                pkt_done_d     = 1'b1;
                pkt_len_d      = plen_q;
                pkt_err_d      = 1'b1;
            end
        end else if (rx_abort_i) begin
            abort_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcnt_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            plen_q       <= '0;
            abort_pend_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_len_q    <= '0;
            pkt_err_q    <= 1'b0;
        end else begin
            bcnt_q       <= bcnt_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            plen_q       <= plen_d;
            abort_pend_q <= abort_pend_d;
            pkt_done_q   <= pkt_done_d;
            pkt_len_q    <= pkt_len_d;
            pkt_err_q    <= pkt_err_d;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (FifoDepth),
        .DATA_TYPE    (pjdl_axis_word_t)
    ) i_out_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (push_word),
        .push_i  (fifo_push),
        .data_o  (fifo_head),
        .pop_i   (axis_rsp_i.tready)
    );

    always_comb begin
        axis_req_o        = '0;
        axis_req_o.tvalid = !fifo_empty;
        axis_req_o.t.data = fifo_head.data;
        axis_req_o.t.strb = fifo_head.strb;
        axis_req_o.t.keep = fifo_head.strb;
        axis_req_o.t.last = fifo_head.last;
    end

    assign pkt_done_o = pkt_done_q;
    assign pkt_len_o  = pkt_len_q;
    assign pkt_err_o  = pkt_err_q;
endmodule

// File: tb/tb_pjdl_rx_axis_packer.sv
// Bench for pjdl_rx_axis_packer: scenario tasks with a packet-level reference model.
module tb_pjdl_rx_axis_packer;
    import pjdl_pkg::*;

    typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} tw_t;
    typedef struct packed {logic [15:0] len; logic err;} ts_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  rx_byte = 8'h00;
    logic        rx_vld = 1'b0, rx_eop = 1'b0, rx_abort = 1'b0, tready = 1'b0;
    logic        rx_rdy, pkt_done, pkt_err;
    logic [15:0] pkt_len;

    pjdl_rx_axis_packer_if axis_if();
    assign axis_if.axis_rsp = '{tready: tready};

    pjdl_rx_axis_packer #(.FifoDepth(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_byte_i(rx_byte), .rx_byte_valid_i(rx_vld), .rx_eop_i(rx_eop),
        .rx_byte_ready_o(rx_rdy), .rx_abort_i(rx_abort),
        .axis_req_o(axis_if.axis_req), .axis_rsp_i(axis_if.axis_rsp),
        .pkt_done_o(pkt_done), .pkt_len_o(pkt_len), .pkt_err_o(pkt_err)
    );

    int tests = 0, failed = 0;
    int stalls = 0, sent = 0;
    tw_t got_q[$], exp_w[$];
    ts_t st_q[$], exp_st[$];
    int  keep_bad = 0, stab_bad = 0;
    logic prev_stall = 1'b0;
    tw_t  prev_w, cur_w;

    assign cur_w = {axis_if.axis_req.t.data, axis_if.axis_req.t.strb, axis_if.axis_req.t.last};

    always @(negedge clk) begin
        if (rst_n) begin
            if (axis_if.axis_req.tvalid && axis_if.axis_req.t.keep !== axis_if.axis_req.t.strb)
                keep_bad <= keep_bad + 1;
            if (prev_stall && (!axis_if.axis_req.tvalid || cur_w !== prev_w))
                stab_bad <= stab_bad + 1;
            if (axis_if.axis_req.tvalid && tready) got_q.push_back(cur_w);
            if (pkt_done) st_q.push_back({pkt_len, pkt_err});
            prev_stall <= axis_if.axis_req.tvalid && !tready;
            prev_w     <= cur_w;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Reference: a packet of n bytes becomes ceil(n/4) words; an aborted one
    // becomes floor(n/4) full words plus a last word holding the remainder.
    function automatic void model_pkt(input logic [7:0] b[$], input bit ab);
        int n, nw, idx;
        tw_t w;
        ts_t s;
        n = b.size();
        if (ab && n == 0) return;
        nw = ab ? (n / 4 + 1) : ((n + 3) / 4);
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                idx = i * 4 + k;
                if (idx < n) begin
                    w.data[8*k +: 8] = b[idx];
                    w.strb[k] = 1'b1;
                end
            end
            w.last = (i == nw - 1);
            exp_w.push_back(w);
        end
        s.len = (n > 65535) ? 16'hFFFF : 16'(n);
        s.err = ab;
        exp_st.push_back(s);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit eop, input bit abt);
        int  waited;
        bit  r;
        waited = 0;
        rx_byte = b; rx_vld = 1'b1; rx_eop = eop;
        while (1) begin
            @(negedge clk);
            r = rx_rdy;
            if (r) rx_abort = abt;
            @(posedge clk); #1;
            rx_abort = 1'b0;
            if (r) break;
            waited++; stalls++;
            if (waited > 1000) begin
                tests++; failed++;
                $display("FAIL send_byte_timeout ready stayed %b, required 1", rx_rdy);
                break;
            end
        end
        if (r) sent++;
        rx_vld = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic abort_pulse();
        rx_abort = 1'b1;
        @(posedge clk); #1;
        rx_abort = 1'b0;
    endtask

    // mode 0: eop; mode 1: abort pulse after k bytes; mode 2: abort together with the eop byte
    task automatic send_pkt(input logic [7:0] b[$], input int mode, input int k, input int gap);
        logic [7:0] sub[$];
        int n;
        n = b.size();
        if (mode == 1) begin
            for (int i = 0; i < k; i++) begin
                send_byte(b[i], 1'b0, 1'b0);
                sub.push_back(b[i]);
                repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            end
            abort_pulse();
            model_pkt(sub, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) begin
                send_byte(b[i], i == n - 1, (mode == 2) && (i == n - 1));
                repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            end
            model_pkt(b, 1'b0);
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((got_q.size() < exp_w.size() || st_q.size() < exp_st.size()) && c < 3000) begin
            @(posedge clk); c++;
        end
        repeat (6) @(posedge clk);
        #1;
        if (c >= 3000) begin
            tests++; failed++;
            $display("FAIL drain_timeout got %0d words, required %0d", got_q.size(), exp_w.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (rx_rdy !== 1'b1) begin failed++; $display("FAIL reset_ready got %b exp 1", rx_rdy); end
        tests++; if (axis_if.axis_req !== '0) begin failed++; $display("FAIL reset_axis got %h exp 0", axis_if.axis_req); end
        tests++; if ({pkt_done, pkt_len, pkt_err} !== 18'h0) begin
            failed++; $display("FAIL reset_status got %b/%h/%b exp 0/0/0", pkt_done, pkt_len, pkt_err); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (rx_rdy !== 1'b1 || axis_if.axis_req.tvalid !== 1'b0) begin
            failed++; $display("FAIL post_reset got rdy %b tvalid %b exp 1/0", rx_rdy, axis_if.axis_req.tvalid); end
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        tready = 1'b1;
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i], i == 7, 1'b0);
            if (i == 2) begin
                tests++; if (axis_if.axis_req.tvalid !== 1'b0) begin failed++; $display("FAIL early_tvalid got %b exp 0", axis_if.axis_req.tvalid); end
            end
            if (i == 3) begin
                tests++; if (axis_if.axis_req.tvalid !== 1'b1 || axis_if.axis_req.t.data !== 32'h04030201) begin
                    failed++; $display("FAIL word_latency got %b/%h exp 1/04030201", axis_if.axis_req.tvalid, axis_if.axis_req.t.data); end
            end
        end
        tests++; if ({pkt_done, pkt_len, pkt_err} !== {1'b1, 16'd8, 1'b0}) begin
            failed++; $display("FAIL done_pulse got %b/%0d/%b exp 1/8/0", pkt_done, pkt_len, pkt_err); end
        @(posedge clk); #1;
        tests++; if (pkt_done !== 1'b0 || pkt_len !== 16'd8) begin
            failed++; $display("FAIL done_hold got %b/%0d exp 0/8", pkt_done, pkt_len); end
        model_pkt(b, 1'b0);
        wait_drain();
        tests++; if (got_q.size() != exp_w.size() || st_q.size() != exp_st.size()) begin
            failed++; $display("FAIL basic_counts got %0d/%0d exp %0d/%0d", got_q.size(), st_q.size(), exp_w.size(), exp_st.size()); end
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_w[i]) begin failed++; $display("FAIL basic_word%0d got %h exp %h", i, got_q[i], exp_w[i]); end
        end
        for (int i = 0; i < exp_st.size() && i < st_q.size(); i++) begin
            tests++; if (st_q[i] !== exp_st[i]) begin failed++; $display("FAIL basic_status%0d got %h exp %h", i, st_q[i], exp_st[i]); end
        end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
    endtask

    task automatic test_five();
        logic [7:0] b[$];
        tready = 1'b1;
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_pkt(b, 0, 0, 1);
        wait_drain();
        tests++; if (got_q.size() != 2 || got_q[1] !== {32'h000000EE, 4'h1, 1'b1}) begin
            failed++; $display("FAIL five_tail got %0d words last %h exp 2 words 000000ee/1/1", got_q.size(), got_q[got_q.size()-1]); end
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_w[i]) begin failed++; $display("FAIL five_word%0d got %h exp %h", i, got_q[i], exp_w[i]); end
        end
        tests++; if (st_q.size() != 1 || st_q[0] !== exp_st[0]) begin
            failed++; $display("FAIL five_status got %0d entries %h exp 1 entry %h", st_q.size(), st_q[0], exp_st[0]); end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
    endtask

    task automatic test_backpressure();
        logic [7:0] b[$];
        int s0;
        tready = 1'b0;
        for (int i = 0; i < 21; i++) b.push_back(8'(i + 1));
        s0 = stalls; sent = 0;
        for (int i = 0; i < 16; i++) send_byte(b[i], 1'b0, 1'b0);
        tests++; if (stalls != s0 || rx_rdy !== 1'b0) begin
            failed++; $display("FAIL fill_ready got stalls %0d rdy %b exp 0/0", stalls - s0, rx_rdy); end
        tests++; if (axis_if.axis_req.tvalid !== 1'b1 || axis_if.axis_req.t.data !== 32'h04030201) begin
            failed++; $display("FAIL full_head got %b/%h exp 1/04030201", axis_if.axis_req.tvalid, axis_if.axis_req.t.data); end
        fork
            for (int i = 16; i < 21; i++) send_byte(b[i], i == 20, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #2;
                tests++; if (rx_rdy !== 1'b0 || sent != 16) begin
                    failed++; $display("FAIL hold_full got rdy %b sent %0d exp 0/16", rx_rdy, sent); end
                tready = 1'b1;
            end
        join
        model_pkt(b, 1'b0);
        wait_drain();
        tests++; if (got_q.size() != exp_w.size() || stab_bad != 0) begin
            failed++; $display("FAIL bp_counts got %0d words unstable %0d exp %0d/0", got_q.size(), stab_bad, exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_w[i]) begin failed++; $display("FAIL bp_word%0d got %h exp %h", i, got_q[i], exp_w[i]); end
        end
        tests++; if (st_q.size() != 1 || st_q[0] !== exp_st[0]) begin
            failed++; $display("FAIL bp_status got %0d entries %h exp 1 entry %h", st_q.size(), st_q[0], exp_st[0]); end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
    endtask

    task automatic test_abort();
        logic [7:0] b[$];
        tready = 1'b1;
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        send_pkt(b, 1, 6, 0);
        b.delete();
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        send_pkt(b, 1, 4, 0);
        wait_drain();
        tests++; if (got_q.size() != 4 || got_q[1].strb !== 4'h3 || got_q[3] !== {32'h0, 4'h0, 1'b1}) begin
            failed++; $display("FAIL abort_shape got %0d words strb1 %h w3 %h exp 4/3/000000000+last", got_q.size(), got_q[1].strb, got_q[3]); end
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_w[i]) begin failed++; $display("FAIL abort_word%0d got %h exp %h", i, got_q[i], exp_w[i]); end
        end
        tests++; if (st_q.size() != 2) begin failed++; $display("FAIL abort_pulses got %0d exp 2", st_q.size()); end
        for (int i = 0; i < exp_st.size() && i < st_q.size(); i++) begin
            tests++; if (st_q[i] !== exp_st[i]) begin failed++; $display("FAIL abort_status%0d got %h exp %h", i, st_q[i], exp_st[i]); end
        end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
        abort_pulse();
        repeat (8) @(posedge clk);
        #1;
        tests++; if (got_q.size() != 0 || st_q.size() != 0 || rx_rdy !== 1'b1 || pkt_len !== 16'd4 || pkt_err !== 1'b1) begin
            failed++; $display("FAIL empty_abort got %0d words %0d pulses rdy %b len %0d err %b exp 0/0/1/4/1",
                got_q.size(), st_q.size(), rx_rdy, pkt_len, pkt_err); end
    endtask

    task automatic test_abort_eop();
        logic [7:0] b[$];
        tready = 1'b1;
        b = '{8'h31, 8'h32, 8'h33};
        send_pkt(b, 2, 0, 0);
        wait_drain();
        tests++; if (got_q.size() != 1 || got_q[0] !== {32'h00333231, 4'h7, 1'b1}) begin
            failed++; $display("FAIL abort_eop_word got %0d words %h exp 1 word 00333231/7/1", got_q.size(), got_q[0]); end
        tests++; if (st_q.size() != 1 || st_q[0] !== exp_st[0] || rx_rdy !== 1'b1) begin
            failed++; $display("FAIL abort_eop_status got %0d pulses %h rdy %b exp 1 pulse %h rdy 1", st_q.size(), st_q[0], rx_rdy, exp_st[0]); end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        int s0;
        tready = 1'b1;
        s0 = stalls;
        for (int p = 0; p < 3; p++) begin
            b.delete();
            for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
            send_pkt(b, 0, 0, 0);
        end
        tests++; if (stalls != s0) begin failed++; $display("FAIL b2b_stalls got %0d exp 0", stalls - s0); end
        wait_drain();
        tests++; if (got_q.size() != exp_w.size() || st_q.size() != exp_st.size()) begin
            failed++; $display("FAIL b2b_counts got %0d/%0d exp %0d/%0d", got_q.size(), st_q.size(), exp_w.size(), exp_st.size()); end
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_w[i]) begin failed++; $display("FAIL b2b_word%0d got %h exp %h", i, got_q[i], exp_w[i]); end
        end
        for (int i = 0; i < exp_st.size() && i < st_q.size(); i++) begin
            tests++; if (st_q[i] !== exp_st[i]) begin failed++; $display("FAIL b2b_status%0d got %h exp %h", i, st_q[i], exp_st[i]); end
        end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        bit stop;
        int len, mode;
        stop = 1'b0;
        fork
            while (!stop) begin
                @(posedge clk); #1;
                tready = ($urandom_range(0, 3) != 0);
            end
            begin
                for (int p = 0; p < 40; p++) begin
                    b.delete();
                    len = $urandom_range(1, 12);
                    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
                    mode = $urandom_range(0, 2);
                    send_pkt(b, mode, $urandom_range(0, len), 1);
                end
                stop = 1'b1;
            end
        join
        tready = 1'b1;
        wait_drain();
        tests++; if (got_q.size() != exp_w.size() || st_q.size() != exp_st.size()) begin
            failed++; $display("FAIL rand_counts got %0d/%0d exp %0d/%0d", got_q.size(), st_q.size(), exp_w.size(), exp_st.size()); end
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_w[i]) begin failed++; $display("FAIL rand_word%0d got %h exp %h", i, got_q[i], exp_w[i]); end
        end
        for (int i = 0; i < exp_st.size() && i < st_q.size(); i++) begin
            tests++; if (st_q[i] !== exp_st[i]) begin failed++; $display("FAIL rand_status%0d got %h exp %h", i, st_q[i], exp_st[i]); end
        end
        tests++; if (stab_bad != 0 || keep_bad != 0) begin
            failed++; $display("FAIL rand_axis_rules got unstable %0d keep %0d exp 0/0", stab_bad, keep_bad); end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        tready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h51 + i), 1'b0, 1'b0);
        tests++; if (axis_if.axis_req.tvalid !== 1'b1) begin failed++; $display("FAIL pre_reset_tvalid got %b exp 1", axis_if.axis_req.tvalid); end
        rst_n = 1'b0;
        #1;
        tests++; if (axis_if.axis_req.tvalid !== 1'b0 || rx_rdy !== 1'b1 || pkt_len !== 16'd0) begin
            failed++; $display("FAIL mid_reset got tvalid %b rdy %b len %0d exp 0/1/0", axis_if.axis_req.tvalid, rx_rdy, pkt_len); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        got_q.delete(); st_q.delete();
        tready = 1'b1;
        b = '{8'h11, 8'h22};
        send_pkt(b, 0, 0, 0);
        wait_drain();
        tests++; if (got_q.size() != 1 || got_q[0] !== exp_w[0] || got_q[0].data !== 32'h00002211) begin
            failed++; $display("FAIL clean_after_reset got %0d words %h exp 1 word %h", got_q.size(), got_q[0], exp_w[0]); end
        tests++; if (st_q.size() != 1 || st_q[0] !== exp_st[0]) begin
            failed++; $display("FAIL clean_status got %0d pulses %h exp 1 pulse %h", st_q.size(), st_q[0], exp_st[0]); end
        got_q.delete(); st_q.delete(); exp_w.delete(); exp_st.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_five();
        test_backpressure();
        test_abort();
        test_abort_eop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, tests run %0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
